// File: rtl/fifo_burst_reader.sv
// Read-side controller for the synchronous 32-bit FIFO: absorbs the one-cycle read latency
// and emits fixed-length bursts on a valid/ready stream through a 3-entry skid buffer.
module fifo_burst_reader #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [FCNT_W-1:0] burst_cnt
);

    localparam int unsigned IssW = $clog2(BURST_LEN + 1);
    localparam logic [IssW-1:0] BurstLenV = IssW'(BURST_LEN);
    localparam logic [IssW-1:0] LastIdx   = IssW'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [IssW-1:0]   iss_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [DATA_W-1:0] buf_data_q [3];
    logic              buf_last_q [3];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [1:0]        buf_cnt_q;
    logic [FCNT_W-1:0] burst_cnt_q;

    logic push, pop, last_accept, credit_ok;

    assign push        = inflight_q;
    assign pop         = m_valid && m_ready;
    assign last_accept = pop && buf_last_q[rd_ptr_q];
    // Words already requested count against the buffer so a push never finds it full.
    assign credit_ok   = ({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < 3'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (fifo_rd && iss_q == LastIdx) state_d = StDrain;
            StDrain: if (last_accept) state_d = enable ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_rd = (state_q == StRun) && !fifo_empty && credit_ok && (iss_q < BurstLenV);
        busy    = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (state_d == StRun && state_q != StRun) begin
                iss_q <= '0;
            end else if (fifo_rd) begin
                iss_q <= iss_q + 1'b1;
            end
            inflight_q      <= fifo_rd;
            inflight_last_q <= fifo_rd && (iss_q == LastIdx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            buf_cnt_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= fifo_data;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            end
            if (push && !pop) begin
                buf_cnt_q <= buf_cnt_q + 2'd1;
            end else if (pop && !push) begin
                buf_cnt_q <= buf_cnt_q - 2'd1;
            end
            if (last_accept) begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        m_valid   = (buf_cnt_q != 2'd0);
        m_data    = m_valid ? buf_data_q[rd_ptr_q] : '0;
        m_last    = m_valid ? buf_last_q[rd_ptr_q] : 1'b0;
        burst_cnt = burst_cnt_q;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the team's synchronous 32-bit FIFO. It drains the FIFO through the FIFO's `rd`/`empty`/`data_out` port and handles the FIFO's one-cycle registered read latency. Words leave on a valid/ready stream grouped into fixed-length bursts, with `m_last` marking each burst's final word. It sits between the FIFO and any downstream consumer that applies back-pressure.

## Interface
- `DATA_W`, 32, data width; matches the FIFO word width.
- `BURST_LEN`, 16, words per burst, 1..1023.
- `FCNT_W`, 16, width of the completed-burst counter.

- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-low reset: asserting it (low) clears all state immediately; release is synchronous to `clk`.
- `enable`  in  1  starts bursts while high; level-sensitive.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_W  FIFO `data_out`; valid in the cycle after a `fifo_rd` edge.
- `fifo_rd`  out  1  FIFO read strobe; combinational from registered state.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts when `m_valid && m_ready`.
- `m_data`  out  DATA_W  head of the output buffer.
- `m_last`  out  1  high with the final word of each burst.
- `busy`  out  1  state is not IDLE.
- `burst_cnt`  out  FCNT_W  number of completed bursts; wraps modulo 2^FCNT_W.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: when `enable`=1 at a clock edge. The issued-word counter `iss` is cleared to 0.
  - RUN: `fifo_rd` = `!fifo_empty && (buf_cnt + inflight) < 3 && iss < BURST_LEN`. Each asserted cycle increments `iss`.
  - RUN -> DRAIN: at the edge where `iss` reaches BURST_LEN.
  - DRAIN -> RUN or IDLE: once the final word of the burst has been accepted. The next state is RUN if `enable`=1 at that edge, otherwise IDLE.
- `inflight` is a 1-bit register: it is set on an edge where `fifo_rd`=1 and cleared otherwise. When set, `fifo_data` is pushed into the buffer at the next edge.
- Output buffer: 3-entry circular buffer of {data, last}.
  - `buf_cnt` ranges 0..3.
  - Push and pop in the same cycle leave `buf_cnt` unchanged.
  - The credit rule guarantees there is never a push when `buf_cnt`=3.
- `last` tag: the word whose read is issued when `iss`=BURST_LEN-1 is tagged last.
- `m_valid` = (`buf_cnt` != 0). `m_data` and `m_last` show the head entry. The head is held stable while `m_valid && !m_ready`.
- `burst_cnt` increments on acceptance of a word whose `m_last`=1.
- `enable` deasserted mid-burst: the current burst always completes; partial bursts are never emitted.
- FIFO empty mid-burst: reads pause and resume when `fifo_empty`=0. The state stays RUN with no timeout.
- `fifo_rd` is never asserted while `fifo_empty`=1.
- Reset mid-operation:
  - State returns to IDLE; the buffer, `iss`, `inflight` and `burst_cnt` are cleared.
  - In-flight FIFO data is discarded.
  - Words already read from the FIFO are lost, which is acceptable.

## Timing
- Reset values: `fifo_rd`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `burst_cnt`=0.
- Start latency, with `enable` sampled high at edge E and the FIFO non-empty:
  - `fifo_rd`=1 in the cycle after E.
  - FIFO data is valid after E+1.
  - It is pushed at E+2, so `m_valid`=1 after E+2: 3 edges from enable.
- Throughput: with `m_ready`=1 and the FIFO never empty, one word per cycle is sustained. There are no bubbles inside a burst.
- Between back-to-back bursts (`enable` held high) there are exactly 2 idle cycles on `m_valid`. These come from the DRAIN -> RUN turnaround and the read latency.
- Back-pressure: while `m_ready`=0, at most 3 words are buffered. `fifo_rd` drops as soon as `buf_cnt + inflight` = 3.
- `busy` rises the cycle after E and falls the cycle after the last word of the final burst is accepted.

## Test plan
- Basic burst: `BURST_LEN`=4, FIFO preloaded with 0x10..0x13, `enable` pulsed for one cycle, `m_ready`=1.
  - Required: 0x10..0x13 on consecutive cycles starting 3 edges after `enable`.
  - `m_last` high only with 0x13; `burst_cnt`=1; `busy`=0 afterwards.
- Back-pressure: `m_ready`=0 for 10 cycles after the first `m_valid`.
  - Required: `fifo_rd` pulses exactly 3 times, then stays low; `m_data` is held at 0x10.
  - On release, all 4 words arrive in order with no loss or duplication.
- Underflow: FIFO holds 2 words of a 4-word burst; the other 2 are written 20 cycles later.
  - Required: 2 words are emitted, the block stays in RUN with `fifo_rd`=0 while empty, then the last 2 words follow and `m_last` is high on the 4th word.
- Continuous operation: `enable` held high with 12 words queued and `BURST_LEN`=4.
  - Required: 3 bursts with 2-cycle gaps between them and `burst_cnt`=3.
  - `fifo_rd` never asserts while `fifo_empty`=1.
- Disable mid-burst: `enable` deasserted after the 2nd word.
  - Required: the burst completes all 4 words, then the block returns to IDLE and no further reads are issued.
- Reset mid-burst: `rst` pulled low with `inflight`=1 and `buf_cnt`=2.
  - Required: all outputs reach their reset values immediately, asynchronously.
  - After release, no stale word appears on `m_data`.
